// File: rtl/match_pkg.sv
// rtl/match_pkg.sv - shared state codes, move bit indices, round result codes and the move priority filter
package match_pkg;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_PRST       = 3'd1;
   localparam logic [2:0] ST_COUNTDOWN  = 3'd2;
   localparam logic [2:0] ST_FIGHT      = 3'd3;
   localparam logic [2:0] ST_ROUND_END  = 3'd4;
   localparam logic [2:0] ST_MATCH_OVER = 3'd5;

   localparam int MV_J  = 5;
   localparam int MV_MR = 4;
   localparam int MV_ML = 3;
   localparam int MV_W  = 2;
   localparam int MV_P  = 1;
   localparam int MV_K  = 0;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   // Only the highest-priority pressed button survives: J > MR > ML > W > P > K.
   function automatic logic [5:0] prio_move(input logic [5:0] mv);
      prio_move = 6'd0;
      if (mv[MV_J])       prio_move[MV_J]  = 1'b1;
      else if (mv[MV_MR]) prio_move[MV_MR] = 1'b1;
      else if (mv[MV_ML]) prio_move[MV_ML] = 1'b1;
      else if (mv[MV_W])  prio_move[MV_W]  = 1'b1;
      else if (mv[MV_P])  prio_move[MV_P]  = 1'b1;
      else if (mv[MV_K])  prio_move[MV_K]  = 1'b1;
   endfunction

endpackage

// File: rtl/move_latch.sv
// rtl/move_latch.sv - per-player button latch, cleared on each step strobe, emitting a registered one-cycle command
module move_latch
   import match_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       i_fight,
   input  logic       i_hold,
   input  logic       i_strobe,
   input  logic [5:0] i_move,
   output logic [5:0] o_cmd
);

   logic [5:0] r_latch;
   logic [5:0] r_cmd;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_latch <= 6'd0;
         r_cmd   <= 6'd0;
      end else begin
         r_cmd <= 6'd0;
         if (!i_fight) begin
            r_latch <= 6'd0;
         end else if (!i_hold) begin
            // A press landing in the strobe cycle itself is kept for the next step.
            if (i_strobe) begin
               r_cmd   <= prio_move(r_latch);
               r_latch <= i_move;
            end else if (i_move != 6'd0) begin
               r_latch <= i_move;
            end
         end
      end
   end

   assign o_cmd = r_cmd;

endmodule

// File: rtl/match_controller.sv
// rtl/match_controller.sv - round/match sequencer: move pacing, player reset pulse, round timer, KO/timeout scoring
// Optional MATCH_PAUSE_EN adds a PAUSE input that freezes timing and commands in COUNTDOWN and FIGHT.
module match_controller
   import match_pkg::*;
#(
   parameter int STEP_DIV      = 4,
   parameter int SEC_STEPS     = 8,
   parameter int ROUND_SECS    = 60,
   parameter int ROUNDS_TO_WIN = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
`ifdef MATCH_PAUSE_EN
   input  logic       PAUSE,
`endif
   input  logic [5:0] P1_IN,
   input  logic [5:0] P2_IN,
   input  logic [1:0] P1_HEALTH,
   input  logic [1:0] P2_HEALTH,
   output logic [5:0] P1_CMD,
   output logic [5:0] P2_CMD,
   output logic       PLAYER_RST,
   output logic [6:0] ROUND_TIME,
   output logic [1:0] P1_WINS,
   output logic [1:0] P2_WINS,
   output logic [1:0] WINNER,
   output logic [2:0] STATE
);

   localparam int CW = $clog2(STEP_DIV);
   localparam int SW = (SEC_STEPS > 1) ? $clog2(SEC_STEPS) : 1;
   localparam logic [CW-1:0] CYC_LAST  = CW'(STEP_DIV - 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(SEC_STEPS - 1);
   localparam logic [1:0]    WIN_GOAL  = 2'(ROUNDS_TO_WIN);

   logic [2:0]    r_state;
   logic          r_player_rst;
   logic [CW-1:0] r_cyc;
   logic [SW-1:0] r_step;
   logic [1:0]    r_secs;
   logic [6:0]    r_time;
   logic [1:0]    r_p1_wins;
   logic [1:0]    r_p2_wins;
   logic [1:0]    r_winner;
   logic [1:0]    r_p1_hp;
   logic [1:0]    r_p2_hp;

   logic [2:0]    w_next;
   logic          w_pause;
   logic          w_run;
   logic          w_step;
   logic          w_sec;
   logic          w_rnd_end;
   logic [1:0]    w_rnd_res;
   logic          w_match_won;
   logic          w_fight;

`ifdef MATCH_PAUSE_EN
   assign w_pause = PAUSE && ((r_state == ST_FIGHT) || (r_state == ST_COUNTDOWN));
`else
   assign w_pause = 1'b0;
`endif

   assign w_fight     = (r_state == ST_FIGHT);
   assign w_run       = ((r_state == ST_COUNTDOWN) || w_fight || (r_state == ST_ROUND_END)) && !w_pause;
   assign w_step      = w_run && (r_cyc == CYC_LAST);
   assign w_sec       = w_step && (r_step == STEP_LAST);
   assign w_match_won = (r_p1_wins == WIN_GOAL) || (r_p2_wins == WIN_GOAL);

   // Decided on registered healths, so a KO lands one cycle after the player FSM reports it.
   always_comb begin
      w_rnd_end = 1'b0;
      w_rnd_res = WIN_NONE;
      if (w_fight) begin
         if ((r_p1_hp == 2'd0) && (r_p2_hp == 2'd0)) begin
            w_rnd_end = 1'b1;
            w_rnd_res = WIN_DRAW;
         end else if (r_p1_hp == 2'd0) begin
            w_rnd_end = 1'b1;
            w_rnd_res = WIN_P2;
         end else if (r_p2_hp == 2'd0) begin
            w_rnd_end = 1'b1;
            w_rnd_res = WIN_P1;
         end else if (r_time == 7'd0) begin
            w_rnd_end = 1'b1;
            if (r_p1_hp > r_p2_hp)      w_rnd_res = WIN_P1;
            else if (r_p2_hp > r_p1_hp) w_rnd_res = WIN_P2;
            else                        w_rnd_res = WIN_DRAW;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE, ST_MATCH_OVER: if (START) w_next = ST_PRST;
         ST_PRST:                w_next = ST_COUNTDOWN;
         ST_COUNTDOWN:           if (w_sec && (r_secs == 2'd2)) w_next = ST_FIGHT;
         ST_FIGHT:               if (w_rnd_end) w_next = ST_ROUND_END;
         ST_ROUND_END:           if (w_sec && (r_secs == 2'd1))
                                    w_next = w_match_won ? ST_MATCH_OVER : ST_PRST;
         default:                w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state      <= ST_IDLE;
         r_player_rst <= 1'b1;
         r_cyc        <= '0;
         r_step       <= '0;
         r_secs       <= 2'd0;
         r_time       <= 7'(ROUND_SECS);
         r_p1_wins    <= 2'd0;
         r_p2_wins    <= 2'd0;
         r_winner     <= WIN_NONE;
         r_p1_hp      <= 2'd0;
         r_p2_hp      <= 2'd0;
      end else begin
         r_state      <= w_next;
         r_player_rst <= (w_next != ST_PRST);
         r_p1_hp      <= P1_HEALTH;
         r_p2_hp      <= P2_HEALTH;

         if (w_next != r_state) begin
            r_cyc  <= '0;
            r_step <= '0;
            r_secs <= 2'd0;
         end else if (w_run) begin
            r_cyc <= w_step ? '0 : r_cyc + 1'b1;
            if (w_step) r_step <= w_sec ? '0 : r_step + 1'b1;
            if (w_sec)  r_secs <= r_secs + 2'd1;
         end

         if (r_state == ST_COUNTDOWN)
            r_time <= 7'(ROUND_SECS);
         else if (w_fight && w_sec && (r_time != 7'd0))
            r_time <= r_time - 7'd1;

         if (((r_state == ST_IDLE) || (r_state == ST_MATCH_OVER)) && START) begin
            r_p1_wins <= 2'd0;
            r_p2_wins <= 2'd0;
            r_winner  <= WIN_NONE;
         end else if (w_rnd_end) begin
            r_winner <= w_rnd_res;
            if ((w_rnd_res == WIN_P1) && (r_p1_wins != 2'd3)) r_p1_wins <= r_p1_wins + 2'd1;
            if ((w_rnd_res == WIN_P2) && (r_p2_wins != 2'd3)) r_p2_wins <= r_p2_wins + 2'd1;
         end
      end
   end

   move_latch u_p1_latch (
      .CLK      (CLK),
      .RST      (RST),
      .i_fight  (w_fight),
      .i_hold   (w_pause),
      .i_strobe (w_step),
      .i_move   (P1_IN),
      .o_cmd    (P1_CMD)
   );

   move_latch u_p2_latch (
      .CLK      (CLK),
      .RST      (RST),
      .i_fight  (w_fight),
      .i_hold   (w_pause),
      .i_strobe (w_step),
      .i_move   (P2_IN),
      .o_cmd    (P2_CMD)
   );

   assign PLAYER_RST = r_player_rst;
   assign ROUND_TIME = r_time;
   assign P1_WINS    = r_p1_wins;
   assign P2_WINS    = r_p2_wins;
   assign WINNER     = r_winner;
   assign STATE      = r_state;

endmodule

// File: tb/tb_match_controller.sv
// tb/tb_match_controller.sv - directed match flow with randomized button traffic checked against a step/second model
module tb_match_controller;

   localparam int SD = 4;
   localparam int SS = 2;
   localparam int RS = 5;
   localparam int RW = 2;

   logic       CLK = 1'b0;
   logic       RST;
   logic       START;
   logic [5:0] P1_IN, P2_IN;
   logic [1:0] P1_HEALTH, P2_HEALTH;
   logic [5:0] P1_CMD, P2_CMD;
   logic       PLAYER_RST;
   logic [6:0] ROUND_TIME;
   logic [1:0] P1_WINS, P2_WINS, WINNER;
   logic [2:0] STATE;

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   match_controller #(
      .STEP_DIV      (SD),
      .SEC_STEPS     (SS),
      .ROUND_SECS    (RS),
      .ROUNDS_TO_WIN (RW)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .START      (START),
`ifdef MATCH_PAUSE_EN
      .PAUSE      (1'b0),
`endif
      .P1_IN      (P1_IN),
      .P2_IN      (P2_IN),
      .P1_HEALTH  (P1_HEALTH),
      .P2_HEALTH  (P2_HEALTH),
      .P1_CMD     (P1_CMD),
      .P2_CMD     (P2_CMD),
      .PLAYER_RST (PLAYER_RST),
      .ROUND_TIME (ROUND_TIME),
      .P1_WINS    (P1_WINS),
      .P2_WINS    (P2_WINS),
      .WINNER     (WINNER),
      .STATE      (STATE)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, output int n);
      n = 0;
      while ((STATE !== s) && (n <= budget)) begin
         tick();
         n++;
      end
   endtask

   function automatic logic [5:0] top_bit(input logic [5:0] v);
      logic found;
      top_bit = 6'd0;
      found   = 1'b0;
      for (int b = 5; b >= 0; b--)
         if (v[b] && !found) begin
            top_bit[b] = 1'b1;
            found      = 1'b1;
         end
   endfunction

   task automatic chk_round(input string tag, input logic [1:0] w, input logic [1:0] c1, input logic [1:0] c2);
      chk({tag, "_state"}, STATE, 3'd4);
      chk({tag, "_winner"}, WINNER, w);
      chk({tag, "_p1_wins"}, P1_WINS, c1);
      chk({tag, "_p2_wins"}, P2_WINS, c2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int         n;
      logic [5:0] in1, in2, lat1, lat2, exp1, exp2;
      logic       strobe;

      RST = 1'b0; START = 1'b0; P1_IN = 6'd0; P2_IN = 6'd0;
      P1_HEALTH = 2'd3; P2_HEALTH = 2'd3;
      tick(); tick();
      chk("rst_state", STATE, 3'd0);
      chk("rst_player_rst", PLAYER_RST, 1'b1);
      chk("rst_p1_cmd", P1_CMD, 6'd0);
      chk("rst_p2_cmd", P2_CMD, 6'd0);
      chk("rst_round_time", ROUND_TIME, 7'(RS));
      chk("rst_wins", {P1_WINS, P2_WINS, WINNER}, 6'd0);
      RST = 1'b1;
      tick();
      chk("idle_hold", STATE, 3'd0);

      // Round 1: start pulse, single-cycle player reset, countdown length
      START = 1'b1;
      tick();
      START = 1'b0;
      chk("prst_state", STATE, 3'd1);
      chk("prst_low", PLAYER_RST, 1'b0);
      tick();
      chk("cd_state", STATE, 3'd2);
      chk("prst_released", PLAYER_RST, 1'b1);
      wait_state(3'd3, 40, n);
      chk("countdown_len", n, 24);
      chk("fight_round_time", ROUND_TIME, 7'(RS));

      // Randomized button traffic; strobe every SD cycles from FIGHT entry
      lat1 = 6'd0; lat2 = 6'd0; exp1 = 6'd0; exp2 = 6'd0;
      for (int k = 0; k < 32; k++) begin
         chk("p1_cmd", P1_CMD, exp1);
         chk("p2_cmd", P2_CMD, exp2);
         chk("round_time", ROUND_TIME, 32'(RS - k / (SD * SS)));
         if (k == 4) chk("mr_cmd", P1_CMD, 6'b010000);
         if (k == 1) begin
            in1 = 6'b011010; in2 = 6'd0;
         end else if ((k == 2) || (k == 3)) begin
            in1 = 6'd0; in2 = 6'd0;
         end else begin
            in1 = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
            in2 = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
         end
         P1_IN = in1; P2_IN = in2;
         strobe = ((k % SD) == SD - 1);
         exp1 = strobe ? top_bit(lat1) : 6'd0;
         exp2 = strobe ? top_bit(lat2) : 6'd0;
         lat1 = strobe ? in1 : ((in1 != 6'd0) ? in1 : lat1);
         lat2 = strobe ? in2 : ((in2 != 6'd0) ? in2 : lat2);
         tick();
      end
      P1_IN = 6'd0; P2_IN = 6'd0;
      chk("p1_cmd_last", P1_CMD, exp1);
      chk("p2_cmd_last", P2_CMD, exp2);

      // P2 knocked out
      P2_HEALTH = 2'd0;
      tick();
      chk("ko_latency", STATE, 3'd3);
      tick();
      P2_HEALTH = 2'd3;
      chk_round("p2_ko", 2'b01, 2'd1, 2'd0);
      wait_state(3'd1, 40, n);
      chk("round_end_len", n, 16);
      chk("prst2_low", PLAYER_RST, 1'b0);

      // Round 2: timeout with P2 ahead on health
      P1_HEALTH = 2'd2;
      wait_state(3'd3, 40, n);
      chk("countdown2_len", n, 25);
      for (int k = 0; k < 40; k++) tick();
      chk("timeout_rt", ROUND_TIME, 7'd0);
      chk("timeout_fight", STATE, 3'd3);
      tick();
      chk_round("timeout", 2'b10, 2'd1, 2'd1);
      chk("timeout_cmd", P1_CMD, 6'd0);
      P1_HEALTH = 2'd3;
      wait_state(3'd3, 60, n);
      chk("to_next_fight", n, 41);

      // Round 3: START ignored in FIGHT, then double KO
      START = 1'b1;
      tick();
      START = 1'b0;
      chk("start_ignored", STATE, 3'd3);
      chk("start_ignored_wins", {P1_WINS, P2_WINS}, 4'b0101);
      P1_HEALTH = 2'd0; P2_HEALTH = 2'd0;
      tick(); tick();
      P1_HEALTH = 2'd3; P2_HEALTH = 2'd3;
      chk_round("draw", 2'b11, 2'd1, 2'd1);
      wait_state(3'd3, 60, n);
      chk("draw_next_fight", n, 41);

      // Round 4: second P1 win takes the match
      P2_HEALTH = 2'd0;
      tick(); tick();
      P2_HEALTH = 2'd3;
      chk_round("match_ko", 2'b01, 2'd2, 2'd1);
      wait_state(3'd5, 40, n);
      chk("to_match_over", n, 16);
      for (int k = 0; k < 5; k++) begin
         P1_IN = 6'($urandom_range(1, 63)); P2_IN = 6'($urandom_range(1, 63));
         tick();
         chk("mo_state", STATE, 3'd5);
         chk("mo_hold", {P1_WINS, P2_WINS, WINNER, PLAYER_RST}, 7'b1001011);
         chk("mo_cmd", {P1_CMD, P2_CMD}, 12'd0);
      end
      P1_IN = 6'd0; P2_IN = 6'd0;
      START = 1'b1;
      tick();
      START = 1'b0;
      chk("restart_state", STATE, 3'd1);
      chk("restart_clear", {P1_WINS, P2_WINS, WINNER}, 6'd0);

      // New match: one P1 win, then async reset with a latched press pending
      wait_state(3'd3, 40, n);
      chk("m2_countdown", n, 25);
      P2_HEALTH = 2'd0;
      tick(); tick();
      P2_HEALTH = 2'd3;
      chk_round("m2_ko", 2'b01, 2'd1, 2'd0);
      wait_state(3'd3, 60, n);
      chk("m2_next_fight", n, 41);
      for (int k = 0; k < 9; k++) tick();
      P1_IN = 6'b100000;
      tick();
      P1_IN = 6'd0;
      chk("pre_rst_rt", ROUND_TIME, 7'd4);
      RST = 1'b0;
      #1;
      chk("async_state", STATE, 3'd0);
      chk("async_player_rst", PLAYER_RST, 1'b1);
      chk("async_cmd", {P1_CMD, P2_CMD}, 12'd0);
      chk("async_rt", ROUND_TIME, 7'(RS));
      chk("async_wins", {P1_WINS, P2_WINS, WINNER}, 6'd0);
      tick();
      RST = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("post_rst_cmd", P1_CMD, 6'd0);
         chk("post_rst_state", STATE, 3'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/match_controller.md
# match_controller

Round and match sequencer for the two-player fighting game. Sits between the raw player button vectors and the two player FSMs. It gates and paces player moves into one-cycle commands, pulses the FSMs' reset between rounds, and runs the round timer. It also detects KO and timeout and counts round wins up to a match winner.

## Interface
Parameters:
- STEP_DIV, 4: CLK cycles per game step; must be ≥2.
- SEC_STEPS, 8: game steps per timer second.
- ROUND_SECS, 60: round timer start value, 1..99.
- ROUNDS_TO_WIN, 2: round wins needed to take the match, 1..3.

Ports:
- CLK in 1: system clock.
- RST in 1: reset, asynchronous, active-low.
- START in 1: level; sampled in IDLE and MATCH_OVER.
- P1_IN in 6: raw P1 buttons {J,MR,ML,W,P,K}, bits 5..0.
- P2_IN in 6: raw P2 buttons, same encoding.
- P1_HEALTH in 2: health from the P1 FSM.
- P2_HEALTH in 2: health from the P2 FSM.
- P1_CMD out 6: paced one-hot command to the P1 FSM.
- P2_CMD out 6: paced one-hot command to the P2 FSM.
- PLAYER_RST out 1: active-low reset to both player FSMs.
- ROUND_TIME out 7: seconds remaining.
- P1_WINS out 2: P1 round-win count.
- P2_WINS out 2: P2 round-win count.
- WINNER out 2: last round result; 00 none, 01 P1, 10 P2, 11 draw.
- STATE out 3: current FSM state code.

## Operation
- States: IDLE(0), PRST(1), COUNTDOWN(2), FIGHT(3), ROUND_END(4), MATCH_OVER(5).
- IDLE:
  - START=1 clears both win counts and WINNER.
  - Then goes to PRST.
- PRST: lasts exactly 1 cycle with PLAYER_RST=0, then COUNTDOWN. PLAYER_RST=1 in every other state.
- COUNTDOWN:
  - ROUND_TIME is loaded with ROUND_SECS.
  - Waits 3 timer seconds, then FIGHT. Input latches are cleared on entry to FIGHT.
- FIGHT, move latching:
  - Each player has a 6-bit latch; any cycle with nonzero input overwrites it.
  - On the step strobe, CMD = priority-filtered latch for 1 cycle. Priority order is J>MR>ML>W>P>K, and only the highest set bit passes.
  - On the same strobe the latch clears. A press arriving in the strobe cycle is captured for the next step.
  - CMD=0 in every other cycle and every other state.
- FIGHT, round-end checks (priority order, evaluated every cycle):
  - Both healths 0 → draw.
  - P1_HEALTH=0 → P2 wins round.
  - P2_HEALTH=0 → P1 wins round.
  - ROUND_TIME=0 → higher health wins; equal health → draw.
- Round end and match end:
  - The winner's count increments and WINNER is set. Draws increment neither count.
  - The state then moves to ROUND_END, which holds 2 timer seconds.
  - If any count equals ROUNDS_TO_WIN, go to MATCH_OVER, else PRST.
- MATCH_OVER: holds all outputs; START=1 → IDLE behaviour (clear counts, then PRST).
- START is ignored in all other states.
- Counts saturate at 3.

## Timing
- Reset values:
  - State IDLE; PLAYER_RST=1; CMDs=0; ROUND_TIME=ROUND_SECS.
  - Wins=0; WINNER=00; latches cleared; dividers=0.
- Step strobe:
  - Cycle divider counts 0..STEP_DIV-1; the strobe is high when it equals STEP_DIV-1.
  - The divider runs only in COUNTDOWN, FIGHT and ROUND_END, and restarts at 0 on entry to each.
- Second strobe:
  - Fires on the SEC_STEPS-th step strobe.
  - In FIGHT, ROUND_TIME decrements on each second strobe and never goes below 0.
- Command latency: a press is seen on CMD 1 to STEP_DIV cycles later, registered output.
- Round-end decision: made on the registered health value, so it falls 1 cycle after the FSM update. The state change is registered on the next edge.
- Asynchronous RST mid-round: immediate return to reset values. Player FSMs are reset by their own RST, not by PLAYER_RST.

## Configuration
- MATCH_PAUSE_EN defined:
  - Adds input port PAUSE (1 bit, level).
  - In FIGHT or COUNTDOWN with PAUSE=1, the dividers freeze, CMDs are forced to 0 and the latches ignore input.
  - Resumes exactly where it stopped.
- MATCH_PAUSE_EN undefined: no PAUSE port; timing is never frozen.

## Structure
- Package match_pkg holds:
  - the state enum and its codes;
  - move bit indices J=5, MR=4, ML=3, W=2, P=1, K=0;
  - WINNER codes.
- Sub-module move_latch, instantiated per player: latch, clear-on-strobe, priority filter, registered CMD.

## Test plan
Parameters for all scenarios: STEP_DIV=4, SEC_STEPS=2, ROUND_SECS=5, ROUNDS_TO_WIN=2.
1. Reset, START=1 for 1 cycle → PLAYER_RST=0 for exactly one cycle. FIGHT entered 24 cycles after COUNTDOWN entry; ROUND_TIME=5.
2. In FIGHT, P1_IN=011010 for one cycle → P1_CMD=010000 (MR) for exactly 1 cycle at the next step strobe, then 0.
3. P2_HEALTH driven to 0 in FIGHT → WINNER=01, P1_WINS=1. ROUND_END for 16 cycles, then PRST.
4. No KO, P1_HEALTH=2, P2_HEALTH=3 → ROUND_TIME reaches 0 after 40 cycles; WINNER=10, P2_WINS increments.
5. Both healths 0 in the same cycle → WINNER=11, counts unchanged. A second P1 KO win leads to MATCH_OVER; a later START clears the counts.
6. RST asserted mid-FIGHT with a latched press → all outputs return to reset values immediately, and no CMD is emitted afterwards.
